// File: rtl/shift_sequencer_pkg.sv
// Shared constants and types for the MIX shift sequencer: F codes, word
// widths, normalisation limits and the sequencer FSM state encoding.
package shift_sequencer_pkg;
  localparam int BYTE_W  = 6;
  localparam int MAG_W   = 30;
  localparam int WORD_W  = 31;
  localparam int ADDR_W  = 12;
  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] F_SLA  = 6'd0;
  localparam logic [FIELD_W-1:0] F_SRA  = 6'd1;
  localparam logic [FIELD_W-1:0] F_SLAX = 6'd2;
  localparam logic [FIELD_W-1:0] F_SRAX = 6'd3;
  localparam logic [FIELD_W-1:0] F_SLC  = 6'd4;
  localparam logic [FIELD_W-1:0] F_SRC  = 6'd5;

  localparam int M_MAX     = 4095;
  localparam int CIRC_WRAP = 5000;
  localparam int CIRC_SUB  = 4000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;
endpackage

// File: rtl/shift_count_norm.sv
// Combinational shift-count former: M = +-AA + rI, sign resolution and range
// normalisation. MIX_SHIFT_NEGM_EN turns a negative M into a reversed shift.
module shift_count_norm
  import shift_sequencer_pkg::*;
(
  input  logic [FIELD_W-1:0] i_field,
  input  logic               i_aa_s,
  input  logic [ADDR_W-1:0]  i_aa,
  input  logic               i_ri_s,
  input  logic [ADDR_W-1:0]  i_ri,
  output logic [FIELD_W-1:0] o_field,
  output logic [ADDR_W-1:0]  o_m,
  output logic               o_fault
);
  logic signed [ADDR_W+1:0] w_aa;
  logic signed [ADDR_W+1:0] w_ri;
  logic signed [ADDR_W+1:0] w_sum;
  logic                     w_neg;
  logic [ADDR_W:0]          w_mag;
  logic [FIELD_W-1:0]       w_field;

  always_comb begin
    w_aa  = i_aa_s ? -$signed({2'b00, i_aa}) : $signed({2'b00, i_aa});
    w_ri  = i_ri_s ? -$signed({2'b00, i_ri}) : $signed({2'b00, i_ri});
    w_sum = w_aa + w_ri;
    // A -0 sum is numerically zero, so it never takes the negative path.
    w_neg = w_sum[ADDR_W+1];
    w_mag = w_neg ? (ADDR_W+1)'(-w_sum) : w_sum[ADDR_W:0];

    o_fault = (i_field > F_SRC);
    w_field = i_field;
`ifdef MIX_SHIFT_NEGM_EN
    if (w_neg) w_field = i_field ^ 6'd1;
`else
    if (w_neg) o_fault = 1'b1;
`endif
    o_field = w_field;

    // Circular shifts by multiples of 10 bytes are identities, so wrap by
    // 5000/4000; linear shifts past the word just saturate.
    o_m = ADDR_W'(w_mag);
    if (w_field >= F_SLC) begin
      if (w_mag >= (ADDR_W+1)'(CIRC_WRAP))
        o_m = ADDR_W'(w_mag - (ADDR_W+1)'(CIRC_WRAP));
      else if (w_mag > (ADDR_W+1)'(M_MAX))
        o_m = ADDR_W'(w_mag - (ADDR_W+1)'(CIRC_SUB));
    end else if (w_mag > (ADDR_W+1)'(M_MAX)) begin
      o_m = ADDR_W'(M_MAX);
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// MIX C=6 shift sequencer: latches a request, normalises M, drives the shift
// unit and returns signed rA/rX or a fault. Optional: MIX_SHIFT_NEGM_EN.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WDOG = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FIELD_W-1:0] req_field,
  input  logic               req_aa_s,
  input  logic [ADDR_W-1:0]  req_aa,
  input  logic               req_ri_s,
  input  logic [ADDR_W-1:0]  req_ri,
  input  logic [WORD_W-1:0]  req_ra,
  input  logic [WORD_W-1:0]  req_rx,
  output logic               sh_start,
  output logic [FIELD_W-1:0] sh_field,
  output logic [ADDR_W-1:0]  sh_m,
  output logic [MAG_W-1:0]   sh_ina,
  output logic [MAG_W-1:0]   sh_inx,
  input  logic               sh_stop,
  input  logic [MAG_W-1:0]   sh_outa,
  input  logic [MAG_W-1:0]   sh_outx,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_ra,
  output logic [WORD_W-1:0]  rsp_rx,
  output logic               rsp_fault,
  output logic               busy
);
  localparam int WD_W = (WDOG > 1) ? $clog2(WDOG) : 1;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_busy;
  logic [FIELD_W-1:0] r_field;
  logic               r_aa_s;
  logic [ADDR_W-1:0]  r_aa;
  logic               r_ri_s;
  logic [ADDR_W-1:0]  r_ri;
  logic [WORD_W-1:0]  r_ra;
  logic [WORD_W-1:0]  r_rx;
  logic               r_sh_start;
  logic [FIELD_W-1:0] r_sh_field;
  logic [ADDR_W-1:0]  r_sh_m;
  logic [MAG_W-1:0]   r_sh_ina;
  logic [MAG_W-1:0]   r_sh_inx;
  logic               r_rsp_valid;
  logic [WORD_W-1:0]  r_rsp_ra;
  logic [WORD_W-1:0]  r_rsp_rx;
  logic               r_rsp_fault;
  logic [WD_W-1:0]    r_wdog;

  logic [FIELD_W-1:0] w_field;
  logic [ADDR_W-1:0]  w_m;
  logic               w_fault;

  shift_count_norm u_norm (
    .i_field (r_field),
    .i_aa_s  (r_aa_s),
    .i_aa    (r_aa),
    .i_ri_s  (r_ri_s),
    .i_ri    (r_ri),
    .o_field (w_field),
    .o_m     (w_m),
    .o_fault (w_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_field     <= '0;
      r_aa_s      <= 1'b0;
      r_aa        <= '0;
      r_ri_s      <= 1'b0;
      r_ri        <= '0;
      r_ra        <= '0;
      r_rx        <= '0;
      r_sh_start  <= 1'b0;
      r_sh_field  <= '0;
      r_sh_m      <= '0;
      r_sh_ina    <= '0;
      r_sh_inx    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_ra    <= '0;
      r_rsp_rx    <= '0;
      r_rsp_fault <= 1'b0;
      r_wdog      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_field     <= req_field;
            r_aa_s      <= req_aa_s;
            r_aa        <= req_aa;
            r_ri_s      <= req_ri_s;
            r_ri        <= req_ri;
            r_ra        <= req_ra;
            r_rx        <= req_rx;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_fault) begin
            r_rsp_ra    <= r_ra;
            r_rsp_rx    <= r_rx;
            r_rsp_fault <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_sh_field <= w_field;
            r_sh_m     <= w_m;
            r_sh_ina   <= r_ra[MAG_W-1:0];
            r_sh_inx   <= r_rx[MAG_W-1:0];
            r_sh_start <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sh_start <= 1'b0;
          r_wdog     <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (sh_stop) begin
            r_rsp_ra    <= {r_ra[WORD_W-1], sh_outa};
            r_rsp_rx    <= {r_rx[WORD_W-1], sh_outx};
            r_rsp_fault <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_wdog == WD_W'(WDOG - 1)) begin
            r_rsp_ra    <= r_ra;
            r_rsp_rx    <= r_rx;
            r_rsp_fault <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_sh_start  <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign sh_start  = r_sh_start;
  assign sh_field  = r_sh_field;
  assign sh_m      = r_sh_m;
  assign sh_ina    = r_sh_ina;
  assign sh_inx    = r_sh_inx;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ra    = r_rsp_ra;
  assign rsp_rx    = r_rsp_rx;
  assign rsp_fault = r_rsp_fault;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; the bench plays the shift unit and
// returns hand-computed results. Honours MIX_SHIFT_NEGM_EN like the RTL.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_field = '0;
  logic        req_aa_s = 1'b0;
  logic [11:0] req_aa = '0;
  logic        req_ri_s = 1'b0;
  logic [11:0] req_ri = '0;
  logic [30:0] req_ra = '0;
  logic [30:0] req_rx = '0;
  logic        sh_start;
  logic [5:0]  sh_field;
  logic [11:0] sh_m;
  logic [29:0] sh_ina;
  logic [29:0] sh_inx;
  logic        sh_stop = 1'b0;
  logic [29:0] sh_outa = '0;
  logic [29:0] sh_outx = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [30:0] rsp_ra;
  logic [30:0] rsp_rx;
  logic        rsp_fault;
  logic        busy;

  int checks = 0;
  int failures = 0;

  int          obs_start, obs_rsp;
  logic [5:0]  obs_f;
  logic [11:0] obs_m;
  logic [30:0] obs_ra, obs_rx;
  logic        obs_fault;
  bit          obs_stable, obs_idle, obs_rdy1;

  shift_sequencer #(.WDOG(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_field(req_field),
    .req_aa_s(req_aa_s), .req_aa(req_aa), .req_ri_s(req_ri_s), .req_ri(req_ri),
    .req_ra(req_ra), .req_rx(req_rx),
    .sh_start(sh_start), .sh_field(sh_field), .sh_m(sh_m), .sh_ina(sh_ina), .sh_inx(sh_inx),
    .sh_stop(sh_stop), .sh_outa(sh_outa), .sh_outx(sh_outx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ra(rsp_ra), .rsp_rx(rsp_rx),
    .rsp_fault(rsp_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] mw(input logic s, input int b1, b2, b3, b4, b5);
    return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
  endfunction

  // One request through the sequencer; cycle 0 is the accepting edge.
  task automatic run_txn(input logic [5:0] f, input logic aas, input logic [11:0] aa,
                         input logic ris, input logic [11:0] ri,
                         input logic [30:0] ra, input logic [30:0] rx,
                         input logic [29:0] oa, input logic [29:0] ox,
                         input bit respond, input int hold);
    int cyc;
    @(negedge clk);
    req_field = f; req_aa_s = aas; req_aa = aa; req_ri_s = ris; req_ri = ri;
    req_ra = ra; req_rx = rx; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    obs_rdy1 = (req_ready == 1'b0 && busy == 1'b1);
    cyc = 1; obs_start = -1; obs_rsp = -1; obs_f = 'x; obs_m = 'x;
    while (cyc < 30 && rsp_valid !== 1'b1) begin
      if (sh_start === 1'b1) begin obs_start = cyc; obs_f = sh_field; obs_m = sh_m; end
      @(negedge clk);
      cyc++;
      sh_stop = respond && (obs_start >= 0) && (cyc == obs_start + 1);
      sh_outa = sh_stop ? oa : 30'd0;
      sh_outx = sh_stop ? ox : 30'd0;
    end
    sh_stop = 1'b0;
    if (rsp_valid === 1'b1) obs_rsp = cyc;
    obs_ra = rsp_ra; obs_rx = rsp_rx; obs_fault = rsp_fault;
    obs_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_ra !== obs_ra || rsp_rx !== obs_rx || rsp_fault !== obs_fault ||
          rsp_valid !== 1'b1 || req_ready !== 1'b0) obs_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_idle = (rsp_valid === 1'b0 && req_ready === 1'b1 && busy === 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (sh_start !== 1'b0) begin failures++; $display("FAIL reset_sh_start got=%0b exp=0", sh_start); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if ({rsp_fault, rsp_ra, rsp_rx, sh_m} !== '0) begin failures++; $display("FAIL reset_payload got=%0h exp=0", {rsp_fault, rsp_ra, rsp_rx, sh_m}); end
  endtask

  task automatic test_sla();
    run_txn(6'd0, 1'b0, 12'd2, 1'b0, 12'd0, mw(0,1,2,3,4,5), 31'd0,
            mw(0,3,4,5,0,0), 30'd0, 1'b1, 0);
    checks++; if (obs_rdy1 !== 1'b1) begin failures++; $display("FAIL sla_busy_c1 got=%0b exp=1", obs_rdy1); end
    checks++; if (obs_start !== 2) begin failures++; $display("FAIL sla_start_cyc got=%0d exp=2", obs_start); end
    checks++; if (obs_rsp !== 4) begin failures++; $display("FAIL sla_rsp_cyc got=%0d exp=4", obs_rsp); end
    checks++; if (obs_f !== 6'd0 || obs_m !== 12'd2) begin failures++; $display("FAIL sla_sh got f=%0d m=%0d exp f=0 m=2", obs_f, obs_m); end
    checks++; if (obs_ra !== mw(0,3,4,5,0,0) || obs_fault !== 1'b0) begin failures++; $display("FAIL sla_ra got=%0h f=%0b exp=%0h f=0", obs_ra, obs_fault, mw(0,3,4,5,0,0)); end
    checks++; if (obs_idle !== 1'b1) begin failures++; $display("FAIL sla_idle got=%0b exp=1", obs_idle); end
  endtask

  task automatic test_srax();
    run_txn(6'd3, 1'b0, 12'd1, 1'b0, 12'd0, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10),
            mw(0,0,1,2,3,4), mw(0,5,6,7,8,9), 1'b1, 0);
    checks++; if (obs_f !== 6'd3 || obs_m !== 12'd1) begin failures++; $display("FAIL srax_sh got f=%0d m=%0d exp f=3 m=1", obs_f, obs_m); end
    checks++; if (obs_ra !== mw(1,0,1,2,3,4)) begin failures++; $display("FAIL srax_ra got=%0h exp=%0h", obs_ra, mw(1,0,1,2,3,4)); end
    checks++; if (obs_rx !== mw(0,5,6,7,8,9)) begin failures++; $display("FAIL srax_rx got=%0h exp=%0h", obs_rx, mw(0,5,6,7,8,9)); end
  endtask

  task automatic test_slc();
    run_txn(6'd4, 1'b0, 12'd500, 1'b0, 12'd1, mw(0,1,2,3,4,5), mw(0,6,7,8,9,10),
            mw(0,2,3,4,5,6), mw(0,7,8,9,10,1), 1'b1, 0);
    checks++; if (obs_m !== 12'd501) begin failures++; $display("FAIL slc_m got=%0d exp=501", obs_m); end
    checks++; if (obs_ra !== mw(0,2,3,4,5,6) || obs_rx !== mw(0,7,8,9,10,1)) begin failures++; $display("FAIL slc_regs got=%0h/%0h exp=%0h/%0h", obs_ra, obs_rx, mw(0,2,3,4,5,6), mw(0,7,8,9,10,1)); end
    run_txn(6'd4, 1'b0, 12'd4095, 1'b0, 12'd4095, mw(0,1,2,3,4,5), mw(1,6,7,8,9,10),
            mw(0,1,2,3,4,5), mw(0,6,7,8,9,10), 1'b1, 0);
    checks++; if (obs_m !== 12'd3190) begin failures++; $display("FAIL slc_wrap_m got=%0d exp=3190", obs_m); end
    checks++; if (obs_ra !== mw(0,1,2,3,4,5) || obs_rx !== mw(1,6,7,8,9,10)) begin failures++; $display("FAIL slc_wrap_regs got=%0h/%0h exp=%0h/%0h", obs_ra, obs_rx, mw(0,1,2,3,4,5), mw(1,6,7,8,9,10)); end
    run_txn(6'd5, 1'b0, 12'd4095, 1'b0, 12'd905, 31'd0, 31'd0, 30'd0, 30'd0, 1'b1, 0);
    checks++; if (obs_m !== 12'd0) begin failures++; $display("FAIL src_5000_m got=%0d exp=0", obs_m); end
    run_txn(6'd5, 1'b0, 12'd4095, 1'b0, 12'd1, 31'd0, 31'd0, 30'd0, 30'd0, 1'b1, 0);
    checks++; if (obs_m !== 12'd96) begin failures++; $display("FAIL src_4096_m got=%0d exp=96", obs_m); end
    run_txn(6'd5, 1'b0, 12'd4050, 1'b0, 12'd0, 31'd0, 31'd0, 30'd0, 30'd0, 1'b1, 0);
    checks++; if (obs_m !== 12'd4050) begin failures++; $display("FAIL src_4050_m got=%0d exp=4050", obs_m); end
    run_txn(6'd0, 1'b0, 12'd4095, 1'b0, 12'd10, mw(0,1,2,3,4,5), 31'd0, 30'd0, 30'd0, 1'b1, 0);
    checks++; if (obs_m !== 12'd4095 || obs_ra !== mw(0,0,0,0,0,0)) begin failures++; $display("FAIL sla_clamp got m=%0d ra=%0h exp m=4095 ra=0", obs_m, obs_ra); end
  endtask

  task automatic test_negm();
    run_txn(6'd0, 1'b1, 12'd3, 1'b0, 12'd1, mw(0,1,2,3,4,5), 31'd0,
            mw(0,0,0,1,2,3), 30'd0, 1'b1, 0);
`ifdef MIX_SHIFT_NEGM_EN
    checks++; if (obs_f !== 6'd1 || obs_m !== 12'd2) begin failures++; $display("FAIL negm_sh got f=%0d m=%0d exp f=1 m=2", obs_f, obs_m); end
    checks++; if (obs_ra !== mw(0,0,0,1,2,3) || obs_fault !== 1'b0) begin failures++; $display("FAIL negm_ra got=%0h f=%0b exp=%0h f=0", obs_ra, obs_fault, mw(0,0,0,1,2,3)); end
    checks++; if (obs_rsp !== 4) begin failures++; $display("FAIL negm_rsp_cyc got=%0d exp=4", obs_rsp); end
`else
    checks++; if (obs_fault !== 1'b1) begin failures++; $display("FAIL negm_fault got=%0b exp=1", obs_fault); end
    checks++; if (obs_ra !== mw(0,1,2,3,4,5)) begin failures++; $display("FAIL negm_ra got=%0h exp=%0h", obs_ra, mw(0,1,2,3,4,5)); end
    checks++; if (obs_start !== -1 || obs_rsp !== 2) begin failures++; $display("FAIL negm_timing got start=%0d rsp=%0d exp start=-1 rsp=2", obs_start, obs_rsp); end
`endif
    run_txn(6'd0, 1'b1, 12'd0, 1'b1, 12'd0, mw(0,1,2,3,4,5), 31'd0,
            mw(0,1,2,3,4,5), 30'd0, 1'b1, 0);
    checks++; if (obs_fault !== 1'b0 || obs_start !== 2) begin failures++; $display("FAIL minus_zero got fault=%0b start=%0d exp fault=0 start=2", obs_fault, obs_start); end
    checks++; if (obs_f !== 6'd0 || obs_m !== 12'd0) begin failures++; $display("FAIL minus_zero_sh got f=%0d m=%0d exp f=0 m=0", obs_f, obs_m); end
  endtask

  task automatic test_bad_field();
    run_txn(6'd6, 1'b0, 12'd1, 1'b0, 12'd0, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10),
            30'd0, 30'd0, 1'b1, 0);
    checks++; if (obs_rsp !== 2) begin failures++; $display("FAIL f6_rsp_cyc got=%0d exp=2", obs_rsp); end
    checks++; if (obs_fault !== 1'b1 || obs_start !== -1) begin failures++; $display("FAIL f6_fault got fault=%0b start=%0d exp fault=1 start=-1", obs_fault, obs_start); end
    checks++; if (obs_ra !== mw(1,1,2,3,4,5) || obs_rx !== mw(0,6,7,8,9,10)) begin failures++; $display("FAIL f6_regs got=%0h/%0h exp=%0h/%0h", obs_ra, obs_rx, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10)); end
  endtask

  task automatic test_watchdog();
    run_txn(6'd1, 1'b0, 12'd2, 1'b0, 12'd0, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10),
            30'd0, 30'd0, 1'b0, 0);
    checks++; if (obs_start !== 2) begin failures++; $display("FAIL wdog_start got=%0d exp=2", obs_start); end
    checks++; if (obs_rsp !== 6) begin failures++; $display("FAIL wdog_rsp_cyc got=%0d exp=6", obs_rsp); end
    checks++; if (obs_fault !== 1'b1) begin failures++; $display("FAIL wdog_fault got=%0b exp=1", obs_fault); end
    checks++; if (obs_ra !== mw(1,1,2,3,4,5) || obs_rx !== mw(0,6,7,8,9,10)) begin failures++; $display("FAIL wdog_regs got=%0h/%0h exp=%0h/%0h", obs_ra, obs_rx, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10)); end
  endtask

  task automatic test_back_pressure();
    run_txn(6'd2, 1'b0, 12'd1, 1'b0, 12'd0, mw(1,1,2,3,4,5), mw(0,6,7,8,9,10),
            mw(0,2,3,4,5,6), mw(0,7,8,9,10,0), 1'b1, 3);
    checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%0b exp=1", obs_stable); end
    checks++; if (obs_ra !== mw(1,2,3,4,5,6) || obs_rx !== mw(0,7,8,9,10,0)) begin failures++; $display("FAIL bp_regs got=%0h/%0h exp=%0h/%0h", obs_ra, obs_rx, mw(1,2,3,4,5,6), mw(0,7,8,9,10,0)); end
    checks++; if (obs_idle !== 1'b1) begin failures++; $display("FAIL bp_idle got=%0b exp=1", obs_idle); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_field = 6'd0; req_aa_s = 1'b0; req_aa = 12'd1; req_ri_s = 1'b0; req_ri = 12'd0;
    req_ra = mw(0,1,2,3,4,5); req_rx = 31'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (sh_start !== 1'b1) begin failures++; $display("FAIL mid_issue got=%0b exp=1", sh_start); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_ctrl got busy=%0b rdy=%0b exp busy=0 rdy=1", busy, req_ready); end
    checks++; if (sh_start !== 1'b0 || sh_m !== 12'd0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_outs got start=%0b m=%0d vld=%0b exp 0/0/0", sh_start, sh_m, rsp_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sh_stop = 1'b1;
    repeat (3) @(negedge clk);
    sh_stop = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got vld=%0b busy=%0b exp 0/0", rsp_valid, busy); end
    run_txn(6'd0, 1'b0, 12'd1, 1'b0, 12'd0, mw(0,1,2,3,4,5), 31'd0,
            mw(0,2,3,4,5,0), 30'd0, 1'b1, 0);
    checks++; if (obs_rsp !== 4 || obs_m !== 12'd1) begin failures++; $display("FAIL mid_next got rsp=%0d m=%0d exp rsp=4 m=1", obs_rsp, obs_m); end
    checks++; if (obs_ra !== mw(0,2,3,4,5,0)) begin failures++; $display("FAIL mid_next_ra got=%0h exp=%0h", obs_ra, mw(0,2,3,4,5,0)); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sla();
    test_srax();
    test_slc();
    test_negm();
    test_bad_field();
    test_watchdog();
    test_back_pressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
